// File: rtl/isa_pkg.sv
// Shared ISA definitions for the multi-cycle control sequencer: opcodes,
// datapath select encodings and the controller state enumeration.
package isa_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NDU  = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_TWO   = 2'b01;
    localparam logic [1:0] SRCB_SEXT6 = 2'b10;
    localparam logic [1:0] SRCB_SEXT9 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_PCREL  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    function automatic logic is_legal_opcode(input logic [3:0] op);
        return op inside {OP_ADD, OP_NDU, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_HALT};
    endfunction

    // States that hold until the shared memory port reports completion.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    function automatic logic [1:0] r_type_alu_op(input logic [3:0] op);
        return (op == OP_NDU) ? ALU_NAND : ALU_ADD;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive memory wait cycles; flags expiry when the TIMEOUT-th
// consecutive wait cycle still has no memory completion.
module ctrl_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values regardless of the order processes are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (waiting) begin
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the number of earlier wait cycles, so TIMEOUT-1 marks
    // the TIMEOUT-th one.
    assign expired = waiting && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control sequencer for the 16-bit multi-cycle shared-memory datapath,
// with memory wait handshake, wait watchdog and retired-instruction counter.
module multicycle_ctrl_fsm
    import isa_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dest,
    output logic             mem_to_reg,
    output logic             jal_link,
    output logic             halted,
    output logic             illegal,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retire_count,
    output logic [3:0]       state
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_retire;
    logic             w_waiting;
    logic             w_expired;
    logic             w_wait_clear;
    logic             w_zero_unused;
    logic             r_illegal;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_retire_count;

    // The zero flag is qualified in the datapath, not here.
    assign w_zero_unused = zero;

    assign w_waiting    = is_wait_state(r_state) && !mem_ready;
    assign w_wait_clear = (w_next_state != r_state);

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_wait_clear),
        .waiting (w_waiting),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default first so
    // that no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)      w_next_state = S_DECODE;
                else if (w_expired) w_next_state = S_HALT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_NDU: w_next_state = S_EXEC_R;
                    OP_LW, OP_SW:   w_next_state = S_MEM_ADDR;
                    OP_BEQ:         w_next_state = S_BRANCH;
                    OP_JAL:         w_next_state = S_JAL;
                    default:        w_next_state = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                w_next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready)      w_next_state = S_MEM_WB;
                else if (w_expired) w_next_state = S_HALT;
            end
            S_MEM_WR: begin
                if (mem_ready)      w_retire     = 1'b1;
                else if (w_expired) w_next_state = S_HALT;
            end
            S_EXEC_R: w_next_state = S_R_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JAL: w_retire = 1'b1;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
        // run is only consulted on the retiring edge, never mid-instruction.
        if (w_retire) w_next_state = run ? S_FETCH : S_IDLE;
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dest      = 1'b0;
        mem_to_reg    = 1'b0;
        jal_link      = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_TWO;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_SEXT6;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT6;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_type_alu_op(opcode);
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
                alu_op    = r_type_alu_op(opcode);
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JAL: begin
                reg_write = 1'b1;
                jal_link  = 1'b1;
                pc_write  = 1'b1;
                pc_source = PCSRC_PCREL;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal      <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_retire_count <= '0;
        end else begin
            if ((r_state == S_DECODE) && !is_legal_opcode(opcode)) begin
                r_illegal <= 1'b1;
            end
            if (w_expired) begin
                r_timeout_err <= 1'b1;
            end
            if (w_retire && (r_retire_count != '1)) begin
                r_retire_count <= r_retire_count + 1'b1;
            end
        end
    end

    assign illegal      = r_illegal;
    assign timeout_err  = r_timeout_err;
    assign retire_count = r_retire_count;
    assign state        = r_state;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Moore control sequencer that runs the team's 16-bit ISA over a multi-cycle, shared-memory datapath. That datapath uses one ALU, one unified instruction/data memory port, and holding registers IR, MDR and ALUOut.
- Supported opcodes: ADD, NDU, LW, SW, BEQ, JAL, and a HALT opcode.
- Adds a memory wait handshake, a wait-timeout watchdog and a retired-instruction counter.
- Sits beside the datapath and replaces the single-cycle combinational control decoder.

Parameters:
TIMEOUT, 16, maximum number of cycles a wait state holds with mem_ready=0 before error-halt.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
run  in  1  start/continue execution.
opcode  in  4  IR[15:12] from the datapath.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current read or write this cycle.
pc_write  out  1  unconditional PC load.
pc_write_cond  out  1  PC load qualified by zero (datapath ANDs with zero).
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = PC + sext(IR[8:0]).
ir_write  out  1  load IR from memory read data.
i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
alu_src_a  out  1  0 = PC, 1 = regA.
alu_src_b  out  2  00 = regB, 01 = constant 2, 10 = sext(IR[5:0]), 11 = sext(IR[8:0]).
alu_op  out  2  00 = add, 01 = sub, 10 = nand.
reg_write  out  1  register file write enable.
reg_dest  out  1  destination: 0 = IR[8:6], 1 = IR[5:3].
mem_to_reg  out  1  write-back data: 1 = MDR, 0 = ALUOut.
jal_link  out  1  write-back data = PC (overrides mem_to_reg).
halted  out  1  FSM is in HALT.
illegal  out  1  sticky: halted on an undefined opcode.
timeout_err  out  1  sticky: halted on a wait timeout.
retire_count  out  CNT_W  instructions completed.
state  out  4  current state encoding, for debug.

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - Every control output = 0.
  - illegal = 0, timeout_err = 0, halted = 0.
  - retire_count = 0, wait counter = 0.
- Outputs are pure decodes of the state register. The only exceptions are ir_write and pc_write in FETCH, which are gated by mem_ready.
- States and encodings:
  - IDLE 0: all outputs 0. Go to FETCH when run=1.
  - FETCH 1:
    - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
    - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
    - Otherwise hold.
  - DECODE 2:
    - Drives alu_src_a=0, alu_src_b=10, alu_op=00; ALUOut captures the branch target.
    - Next state by opcode:
      - 0000 or 0010 → EXEC_R.
      - 0100 or 0101 → MEM_ADDR.
      - 1100 → BRANCH.
      - 1000 → JAL.
      - 1111 → HALT.
      - Any other opcode → HALT with illegal set.
  - MEM_ADDR 3: drives alu_src_a=1, alu_src_b=10, alu_op=00. Next state: LW → MEM_RD, SW → MEM_WR.
  - MEM_RD 4: drives mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
  - MEM_WB 5: drives reg_write=1, reg_dest=0, mem_to_reg=1. Retires.
  - MEM_WR 6: drives mem_write=1, i_or_d=1. Waits for mem_ready, then retires.
  - EXEC_R 7: drives alu_src_a=1, alu_src_b=00, alu_op=00 for ADD or 10 for NDU. Next state R_WB.
  - R_WB 8: drives reg_write=1, reg_dest=1, mem_to_reg=0, and holds alu_op. Retires.
  - BRANCH 9: drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires.
  - JAL 10: drives reg_write=1, reg_dest=0, jal_link=1, pc_write=1, pc_source=10. Retires.
  - HALT 11:
    - All strobes 0, halted=1.
    - Left only by reset; run is ignored.
- Retire:
  - On the retiring edge, retire_count increments and saturates at all-ones.
  - Next state is FETCH if run=1, otherwise IDLE.
- Wait counter (states FETCH, MEM_RD, MEM_WR):
  - Counts each cycle with mem_ready=0 and clears on any state change.
  - If mem_ready=0 on the TIMEOUT-th consecutive wait cycle, go to HALT and set timeout_err.
  - If mem_ready=1 arrives on that same cycle, mem_ready wins and no error is raised.
- run=0 mid-instruction does not abort the instruction; it is sampled only at retire and in IDLE.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronous). Sticky flags and retire_count clear.
- Instruction latency with zero wait states:
  - ADD/NDU 4 cycles.
  - LW 5 cycles.
  - SW 4 cycles.
  - BEQ 3 cycles.
  - JAL 3 cycles.

Decomposition:
- Shared package isa_pkg holds:
  - Opcode constants: OP_ADD=0000, OP_NDU=0010, OP_LW=0100, OP_SW=0101, OP_BEQ=1100, OP_JAL=1000, OP_HALT=1111.
  - ALU op, alu_src_b and pc_source encodings.
  - The state enum.
- One sub-module, ctrl_wait_timer, contains the wait counter and the timeout compare (inputs: clear, waiting; output: expired).

Test Plan:
- Reset, then run=1, mem_ready tied 1, program ADD → state sequence 1,2,7,8,1. reg_write=1 only in R_WB with reg_dest=1. retire_count=1 after 4 cycles.
- LW with mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles, then MEM_WB with mem_to_reg=1. Total 8 cycles. No timeout_err.
- BEQ with zero=1, then BEQ with zero=0 → pc_write_cond=1 and pc_source=01 in both cases, each 3 cycles. retire_count advances by 2.
- TIMEOUT=4, mem_ready held 0 in FETCH → HALT on the 4th wait cycle with timeout_err=1, halted=1. run toggling has no effect until rst_n pulse.
- Opcode 0111 → DECODE then HALT with illegal=1, retire_count unchanged. Opcode 1111 → HALT with illegal=0.
- run dropped during MEM_WR → store completes, mem_write seen once, then IDLE. rst_n asserted in EXEC_R clears all outputs asynchronously, before the next clk edge.
